spi_slave_param: RTL
====================

# spi_slave_param

Parametrised successor to the team's fixed 8-bit SPI slave: serial-to-parallel receive of (2-bit command + DATA_W-bit payload) frames and parallel-to-serial return of read data, clocked directly by the system clock. Sits between the SPI pins and the single-port RAM controller, driving `rx_data`/`rx_valid` into the RAM and taking `tx_data`/`tx_valid` back. Adds configurable payload width, bit order, read-data timeout, command checking and a frame-error flag.

## Interface
- DATA_W, 8: payload width; frame length is DATA_W+2 bits.
- LSB_FIRST, 0: 0 = MSB-first on MOSI and MISO; 1 = LSB-first on both.
- TX_TIMEOUT, 16: maximum number of cycles to wait for `tx_valid` in a read-data frame.

- clk  input  1  system clock; also the SPI bit clock. MOSI is sampled and MISO is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  active-low slave select; framing.
- MOSI  input  1  serial data in.
- tx_valid  input  1  `tx_data` is valid; sampled only in TX_WAIT.
- tx_data  input  DATA_W  read data from the RAM.
- MISO  output  1  serial data out.
- rx_data  output  DATA_W+2  {cmd[1:0], payload}; holds its value until the next completed frame.
- rx_valid  output  1  one-cycle pulse for each completed, correct frame.
- frame_err  output  1  one-cycle pulse when a frame is aborted or rejected.
- busy  output  1  high in every state except IDLE.

## Operation
- Reset values: MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, rd_addr_seen=0.
- Commands: 00 = write address; 01 = write data; 10 = read address; 11 = read data.
- State machine:
  - IDLE → CHK_CMD when SS_n is sampled low.
  - CHK_CMD: samples the first bit into cmd[1]. The next state is chosen as follows:
    - bit 0 → WRITE;
    - bit 1 with rd_addr_seen=0 → READ_ADD;
    - bit 1 with rd_addr_seen=1 → READ_DATA.
  - WRITE, READ_ADD, READ_DATA: shift in the remaining DATA_W+1 bits. The bit counter has width $clog2(DATA_W+2).
    - First remaining bit is cmd[0].
    - Payload order follows LSB_FIRST. rx_data is always stored with the payload MSB at bit DATA_W-1.
  - Frame completion when the last bit is sampled:
    - Expected cmd[0]: READ_ADD expects 0; READ_DATA expects 1; WRITE accepts either.
    - Match: load rx_data and pulse rx_valid.
    - Mismatch: pulse frame_err; rx_data and rd_addr_seen are unchanged.
  - After a correct frame:
    - WRITE or READ_ADD → DONE. A READ_ADD frame also sets rd_addr_seen.
    - READ_DATA → TX_WAIT.
  - TX_WAIT:
    - tx_valid high → latch tx_data, go to TX_SHIFT.
    - TX_TIMEOUT cycles with no tx_valid → pulse frame_err, go to DONE; rd_addr_seen stays set.
  - TX_SHIFT: drives DATA_W bits on MISO, one per cycle, then clears rd_addr_seen and goes to DONE.
  - DONE: MISO=0; stays until SS_n goes high.
- SS_n sampled high in any non-IDLE state → IDLE on that edge, and MISO=0.
  - In CHK_CMD, a shift state, TX_WAIT or TX_SHIFT, this is an abort: frame_err pulses and rd_addr_seen is unchanged.
  - In DONE it is a normal end; no frame_err.
- Extra MOSI bits after the last sampled bit are ignored.

## Timing
- Edge E0 samples SS_n low; E1 samples the first bit; E(DATA_W+2) samples the last bit.
- rx_valid is registered: high for the single cycle after E(DATA_W+2).
- tx_valid sampled high at edge T → first MISO bit is valid after T+1; bit k is valid after T+1+k.
- Minimum cycle counts:
  - read-data transaction: DATA_W+2 + 1 + DATA_W cycles after E0, with tx_valid on the first TX_WAIT cycle;
  - write frame: DATA_W+2 cycles after E0.
- A tx_valid that arrives in the same cycle as the timeout expiry wins (data is latched).
- Reset asserted mid-frame: all outputs return to their reset values immediately; no frame_err.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_state_e`: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE;
  - command localparams CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA.
- One sub-module, `spi_tx_shifter`: load/shift register with a down-counter, parametrised by DATA_W and LSB_FIRST.

## Test plan
- Write-address frame (DATA_W=8), bits 00_1010_0101 → rx_data=0x0A5, rx_valid for one cycle after E10, frame_err=0.
- Read-address frame 10_0000_1111, then read-data frame 11_xxxx_xxxx with tx_data=0x3C and tx_valid on the first TX_WAIT cycle:
  - 0x3C appears MSB-first on MISO over 8 cycles;
  - rd_addr_seen is 0 afterwards.
- LSB_FIRST=1, DATA_W=16, payload 0x1234 sent LSB-first → rx_data={cmd,0x1234}.
- SS_n raised after 5 bits of a write frame → frame_err pulse, no rx_valid, rx_data unchanged, back in IDLE.
- Read-data frame with tx_valid never asserted, TX_TIMEOUT=16 → frame_err exactly 16 cycles after entering TX_WAIT, MISO=0.
- rst_n dropped during TX_SHIFT → MISO, rx_valid and busy go to 0 immediately; the next read frame is treated as a read address (rd_addr_seen=0).

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared states and command codes for the parametrised SPI slave
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    TX_WAIT,
    TX_SHIFT,
    DONE
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - read-data load/shift register with bit down-counter
module spi_tx_shifter #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              bit_out,
  output logic              last
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= CW'(DATA_W);
    end else if (shift && cnt != '0) begin
      sreg <= (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
      cnt  <= cnt - CW'(1);
    end
  end

  assign bit_out = (LSB_FIRST != 0) ? sreg[0] : sreg[DATA_W-1];
  // Asserted while the final bit is the one being presented.
  assign last    = (cnt == CW'(1));

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - SPI slave: command+payload receive, read-data return
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 0,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

  spi_state_e        state, state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic              cmd1, cmd0;
  logic [DATA_W-1:0] payload, payload_nx;
  logic              rd_addr_seen;

  logic shift_st, last_bit, cmd_ok;
  logic accept, err, load_tx, tx_shift, tx_bit, tx_last;

  assign shift_st = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign last_bit = shift_st && (bit_cnt == CNT_W'(DATA_W));
  assign cmd_ok   = (state == WRITE) ||
                    ((state == READ_ADD)  && ({cmd1, cmd0} == CMD_RD_ADDR)) ||
                    ((state == READ_DATA) && ({cmd1, cmd0} == CMD_RD_DATA));
  assign tx_shift = (state == TX_SHIFT) && !SS_n;
  assign busy     = (state != IDLE);

  // rx_data always holds the payload MSB at bit DATA_W-1 regardless of wire order.
  always_comb begin
    payload_nx = '0;
    if (LSB_FIRST != 0) payload_nx = {MOSI, payload[DATA_W-1:1]};
    else                payload_nx = {payload[DATA_W-2:0], MOSI};
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    err      = 1'b0;
    load_tx  = 1'b0;
    if (state != IDLE && SS_n) begin
      state_nx = IDLE;
      err      = (state != DONE);
    end else begin
      case (state)
        IDLE:    if (!SS_n) state_nx = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_nx = WRITE;
          else if (rd_addr_seen) state_nx = READ_DATA;
          else                   state_nx = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (last_bit) begin
            if (cmd_ok) begin
              accept   = 1'b1;
              state_nx = (state == READ_DATA) ? TX_WAIT : DONE;
            end else begin
              err      = 1'b1;
              state_nx = DONE;
            end
          end
        end
        // A tx_valid coinciding with the timeout edge takes priority.
        TX_WAIT: begin
          if (tx_valid) begin
            load_tx  = 1'b1;
            state_nx = TX_SHIFT;
          end else if (wait_cnt == TO_W'(TX_TIMEOUT - 1)) begin
            err      = 1'b1;
            state_nx = DONE;
          end
        end
        TX_SHIFT: if (tx_last) state_nx = DONE;
        DONE:     state_nx = DONE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_seen <= 1'b0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      cmd1         <= 1'b0;
      cmd0         <= 1'b0;
      payload      <= '0;
    end else begin
      rx_valid  <= accept;
      frame_err <= err;
      MISO      <= tx_shift ? tx_bit : 1'b0;
      wait_cnt  <= (state == TX_WAIT) ? wait_cnt + TO_W'(1) : '0;
      if (state == CHK_CMD) begin
        cmd1    <= MOSI;
        bit_cnt <= '0;
      end
      if (shift_st) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == '0) cmd0    <= MOSI;
        else               payload <= payload_nx;
      end
      if (accept) rx_data <= {cmd1, cmd0, payload_nx};
      if (accept && state == READ_ADD) rd_addr_seen <= 1'b1;
      if (tx_shift && tx_last)         rd_addr_seen <= 1'b0;
    end
  end

  spi_tx_shifter #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_tx),
    .shift  (tx_shift),
    .data   (tx_data),
    .bit_out(tx_bit),
    .last   (tx_last)
  );

endmodule
